// File: rtl/drac_initiator.sv
// Word-to-line initiator for the DRAM controller system port with a single 32-byte
// write-combining buffer that drains on miss, full line, read, flush request or idle timeout.
module drac_initiator #(
  parameter int unsigned FLUSH_TIMEOUT = 64,
  parameter int unsigned TIMER_W       = 8
) (
  input  logic         ck,
  input  logic         reset,
  input  logic         req_rd,
  input  logic         req_wr,
  input  logic [29:0]  req_addr,
  input  logic [31:0]  req_wdat,
  input  logic [3:0]   req_be,
  input  logic         flush,
  output logic         req_ack,
  output logic [31:0]  req_rdat,
  output logic         req_rvalid,
  output logic         busy,
  output logic         srd,
  output logic         swr,
  output logic [28:0]  sa,
  output logic [255:0] swdat,
  output logic [31:0]  smsk,
  input  logic [255:0] srdat,
  input  logic         srdy
);

  typedef enum logic [1:0] {StIdle, StWrIssue, StRdIssue, StRdDone} state_e;

  state_e               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [28:0]          sa_q, sa_d;
  logic [255:0]         swdat_q, swdat_d;
  logic [31:0]          smsk_q, smsk_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 ack_q, ack_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdat_q, rdat_d;

  logic [2:0]  lane;
  logic [28:0] req_line;
  logic        line_hit;
  logic        can_take;

  assign lane     = req_addr[2:0];
  assign req_line = {req_addr[29:3], 2'b00};
  assign line_hit = valid_q && (sa_q == req_line);
  // The cycle carrying an ack is blind to requests: the requester is still dropping them.
  assign can_take = !ack_q;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    sa_d     = sa_q;
    swdat_d  = swdat_q;
    smsk_d   = smsk_q;
    timer_d  = timer_q;
    ack_d    = 1'b0;
    rvalid_d = 1'b0;
    rdat_d   = rdat_q;

    unique case (state_q)
      StIdle: begin
        if (can_take && req_rd) begin
          // Reads always go to memory, so a dirty buffer is written back first.
          if (valid_q) begin
            state_d = StWrIssue;
          end else begin
            state_d = StRdIssue;
            sa_d    = req_line;
          end
        end else if (can_take && req_wr) begin
          if (valid_q && !line_hit) begin
            state_d = StWrIssue;
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (req_be[b]) begin
                swdat_d[{lane, 2'(b), 3'b000} +: 8] = req_wdat[8*b +: 8];
                smsk_d[{lane, 2'(b)}]               = 1'b0;
              end
            end
            valid_d = 1'b1;
            sa_d    = req_line;
            timer_d = '0;
            ack_d   = 1'b1;
          end
        end else if (valid_q && (smsk_q == 32'h0)) begin
          state_d = StWrIssue;
        end else if (valid_q && flush) begin
          state_d = StWrIssue;
        end else if (valid_q && (FLUSH_TIMEOUT != 0)) begin
          timer_d = timer_q + 1'b1;
          if (timer_d == TIMER_W'(FLUSH_TIMEOUT)) begin
            state_d = StWrIssue;
          end
        end
      end
      StWrIssue: begin
        if (srdy) begin
          state_d = StIdle;
          valid_d = 1'b0;
          smsk_d  = '1;
          timer_d = '0;
        end
      end
      StRdIssue: begin
        if (srdy) begin
          rdat_d   = srdat[{lane, 5'b00000} +: 32];
          ack_d    = 1'b1;
          rvalid_d = 1'b1;
          state_d  = StRdDone;
        end
      end
      StRdDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      sa_q     <= '0;
      swdat_q  <= '0;
      smsk_q   <= '1;
      timer_q  <= '0;
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      sa_q     <= sa_d;
      swdat_q  <= swdat_d;
      smsk_q   <= smsk_d;
      timer_q  <= timer_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      rdat_q   <= rdat_d;
    end
  end

  assign req_ack    = ack_q;
  assign req_rvalid = rvalid_q;
  assign req_rdat   = rdat_q;
  assign busy       = (state_q != StIdle) || valid_q;
  assign srd        = (state_q == StRdIssue);
  assign swr        = (state_q == StWrIssue);
  assign sa         = sa_q;
  assign swdat      = swdat_q;
  assign smsk       = smsk_q;

endmodule

// File: tb/tb_drac_initiator.sv
// Bench for drac_initiator: directed sequences, a write-combining vector table and a
// randomized phase checked against a byte-level memory model.
module tb_drac_initiator;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic         reset = 1'b1;
  logic         req_rd = 1'b0, req_wr = 1'b0, flush = 1'b0;
  logic [29:0]  req_addr = '0;
  logic [31:0]  req_wdat = '0;
  logic [3:0]   req_be = '0;
  logic         req_ack, req_rvalid, busy, srd, swr;
  logic [31:0]  req_rdat, smsk;
  logic [28:0]  sa;
  logic [255:0] swdat;
  logic [255:0] srdat = '0;
  logic         srdy = 1'b0;

  // Second instance with auto-flush disabled
  logic         req_wr0 = 1'b0;
  logic         ack0, rvalid0, busy0, srd0, swr0;
  logic [31:0]  rdat0, smsk0;
  logic [28:0]  sa0;
  logic [255:0] swdat0;

  drac_initiator #(.FLUSH_TIMEOUT(64), .TIMER_W(8)) dut (
    .ck(ck), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdat(req_wdat), .req_be(req_be), .flush(flush), .req_ack(req_ack),
    .req_rdat(req_rdat), .req_rvalid(req_rvalid), .busy(busy), .srd(srd), .swr(swr),
    .sa(sa), .swdat(swdat), .smsk(smsk), .srdat(srdat), .srdy(srdy)
  );

  drac_initiator #(.FLUSH_TIMEOUT(0), .TIMER_W(8)) dut0 (
    .ck(ck), .reset(reset), .req_rd(1'b0), .req_wr(req_wr0), .req_addr(30'h0000_0400),
    .req_wdat(32'h1234_5678), .req_be(4'hF), .flush(1'b0), .req_ack(ack0),
    .req_rdat(rdat0), .req_rvalid(rvalid0), .busy(busy0), .srd(srd0), .swr(swr0),
    .sa(sa0), .swdat(swdat0), .smsk(smsk0), .srdat(256'h0), .srdy(1'b0)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  // ---------------- responder / monitor (owns srdy, srdat, rmem) ----------------
  typedef struct {
    bit           wr;
    logic [28:0]  sa;
    logic [255:0] dat;
    logic [31:0]  msk;
    int           start;
    int           done;
  } cmd_t;

  cmd_t         cmds[$];
  logic [255:0] rmem[logic [28:0]];
  bit           resp_en = 1'b1, rand_lat = 1'b0, force_rd = 1'b0;
  int           fix_lat = 2;
  logic [255:0] force_line = '0;
  int           stray_req = 0, stray_done = 0;
  int           mon_bad = 0, ack_cnt = 0, swr0_cnt = 0;
  int           cmd_starts = 0, last_start_cyc = 0;
  bit           last_start_wr = 1'b0;
  bit           prev_any = 1'b0, answered = 1'b0;
  int           lat_cnt = 0, cur_lat = 0;
  logic [28:0]  cur_sa;
  logic [255:0] cur_dat, line_tmp;
  logic [31:0]  cur_msk;

  always @(negedge ck) begin
    if (req_ack) ack_cnt++;
    if (swr0) swr0_cnt++;
    if (srd && swr) mon_bad++;
    srdy = 1'b0;
    if (stray_done != stray_req) begin
      srdy = 1'b1;
      stray_done++;
    end
    if (srd || swr) begin
      if (!prev_any) begin
        cmd_starts++;
        last_start_cyc = cyc;
        last_start_wr  = swr;
        cur_sa = sa; cur_dat = swdat; cur_msk = smsk;
        lat_cnt = 0;
        answered = 1'b0;
        cur_lat = rand_lat ? int'($urandom_range(0, 4)) : fix_lat;
      end else if (sa !== cur_sa || (swr && (swdat !== cur_dat || smsk !== cur_msk))) begin
        mon_bad++;
      end
      if (resp_en && !answered) begin
        if (lat_cnt >= cur_lat) begin
          srdy = 1'b1;
          answered = 1'b1;
          cmds.push_back('{wr: swr, sa: sa, dat: swdat, msk: smsk, start: last_start_cyc,
                           done: cyc});
          line_tmp = rmem.exists(sa) ? rmem[sa] : '0;
          if (swr) begin
            for (int i = 0; i < 32; i++) if (!smsk[i]) line_tmp[8*i +: 8] = swdat[8*i +: 8];
            rmem[sa] = line_tmp;
          end else begin
            srdat = force_rd ? force_line : line_tmp;
          end
        end else begin
          lat_cnt++;
        end
      end
    end
    prev_any = srd || swr;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] baddr,
                        input logic [3:0] be, input logic [31:0] wd, output int lat,
                        output logic [31:0] rdata, output bit rv, output int req_cyc,
                        output int ack_cyc);
    @(posedge ck); #1;
    req_rd = rd; req_wr = wr; req_addr = baddr[31:2]; req_be = be; req_wdat = wd;
    req_cyc = cyc; lat = -1; rv = 1'b0; rdata = '0; ack_cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge ck); #1;
      if (req_ack) begin
        lat = i; rv = req_rvalid; rdata = req_rdat; ack_cyc = cyc;
        break;
      end
    end
    req_rd = 1'b0; req_wr = 1'b0;
    if (lat < 0) check("ack_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!(busy == 1'b0 && !srd && !swr) && n < bound) begin
      @(posedge ck); #1; n++;
    end
    if (n >= bound) check("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic pulse_flush();
    @(posedge ck); #1; flush = 1'b1;
    @(posedge ck); #1; flush = 1'b0;
  endtask

  typedef struct {
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_msk;
  } wvec_t;

  wvec_t        tbl[8];
  logic [7:0]   ref_b[128];
  logic [255:0] exp_line;
  logic [31:0]  rdata, exp_w;
  int           lat, rq, ac, n0, w, rsel;
  bit           rv;
  cmd_t         c, c2;

  initial begin
    tbl[0] = '{32'h1000, 4'hF, 32'd0, 32'hFFFF_FFF0};
    tbl[1] = '{32'h1004, 4'hF, 32'd1, 32'hFFFF_FF00};
    tbl[2] = '{32'h1008, 4'hF, 32'd2, 32'hFFFF_F000};
    tbl[3] = '{32'h100C, 4'hF, 32'd3, 32'hFFFF_0000};
    tbl[4] = '{32'h1010, 4'hF, 32'd4, 32'hFFF0_0000};
    tbl[5] = '{32'h1014, 4'hF, 32'd5, 32'hFF00_0000};
    tbl[6] = '{32'h1018, 4'hF, 32'd6, 32'hF000_0000};
    tbl[7] = '{32'h101C, 4'hF, 32'd7, 32'h0000_0000};
    for (int i = 0; i < 128; i++) ref_b[i] = 8'h00;

    // Reset values
    repeat (2) @(posedge ck);
    #1;
    check("rst_srd", srd, 1'b0);
    check("rst_swr", swr, 1'b0);
    check("rst_sa", sa, 29'h0);
    check("rst_swdat", swdat, 256'h0);
    check("rst_smsk", smsk, 32'hFFFF_FFFF);
    check("rst_ack", req_ack, 1'b0);
    check("rst_rvalid", req_rvalid, 1'b0);
    check("rst_rdat", req_rdat, 32'h0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Fill a whole line; it must drain as one full-mask write
    n0 = cmds.size();
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 1'b1, tbl[i].baddr, tbl[i].be, tbl[i].wd, lat, rdata, rv, rq, ac);
      check("fill_ack_lat", lat, 1);
      check("fill_smsk", smsk, tbl[i].exp_msk);
    end
    wait_idle(100);
    check("fill_ncmd", cmds.size(), n0 + 1);
    if (cmds.size() > n0) begin
      c = cmds[n0];
      exp_line = '0;
      for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = k;
      check("fill_wr", c.wr, 1'b1);
      check("fill_sa", c.sa, 29'h200);
      check("fill_msk", c.msk, 32'h0);
      check("fill_dat", c.dat, exp_line);
    end
    @(posedge ck); #1;
    check("fill_busy", busy, 1'b0);

    // Partial write drained by the flush input
    access(1'b0, 1'b1, 32'h2004, 4'b0011, 32'hAABB_CCDD, lat, rdata, rv, rq, ac);
    check("part_ack_lat", lat, 1);
    n0 = cmds.size();
    pulse_flush();
    wait_idle(100);
    check("flush_ncmd", cmds.size(), n0 + 1);
    if (cmds.size() > n0) begin
      c = cmds[n0];
      check("flush_sa", c.sa, 29'h400);
      check("flush_msk", c.msk, 32'hFFFF_FFCF);
      check("flush_dat", c.dat[47:32], 16'hCCDD);
    end

    // Line miss: old line written back before the new write is acked
    access(1'b0, 1'b1, 32'h2004, 4'hF, 32'h1111_2222, lat, rdata, rv, rq, ac);
    check("hit_ack_lat", lat, 1);
    n0 = cmds.size();
    access(1'b0, 1'b1, 32'h3000, 4'hF, 32'h3333_4444, lat, rdata, rv, rq, ac);
    check("miss_ack_delayed", lat > 1, 1'b1);
    check("miss_ncmd", cmds.size(), n0 + 1);
    if (cmds.size() > n0) begin
      c = cmds[n0];
      check("miss_sa", c.sa, 29'h400);
      check("miss_before_ack", c.done < ac, 1'b1);
    end

    // Read with a dirty buffer: write-back, then line read
    access(1'b0, 1'b1, 32'h3008, 4'hF, 32'hDEAD_BEEF, lat, rdata, rv, rq, ac);
    check("rd_pre_ack_lat", lat, 1);
    force_line = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'h1234_5678, 32'hA1, 32'hA0};
    force_rd = 1'b1;
    n0 = cmds.size();
    access(1'b1, 1'b0, 32'h3008, 4'h0, 32'h0, lat, rdata, rv, rq, ac);
    check("rd_ncmd", cmds.size(), n0 + 2);
    if (cmds.size() > n0 + 1) begin
      c = cmds[n0]; c2 = cmds[n0 + 1];
      check("rd_wb_wr", c.wr, 1'b1);
      check("rd_wb_sa", c.sa, 29'h600);
      check("rd_wb_lane2", c.dat[95:64], 32'hDEAD_BEEF);
      check("rd_srd", c2.wr, 1'b0);
      check("rd_srd_sa", c2.sa, 29'h600);
      check("rd_gap", c2.start > c.done + 1, 1'b1);
      check("rd_ack_cyc", ac, c2.done + 1);
    end
    check("rd_data", rdata, 32'h1234_5678);
    check("rd_rvalid", rv, 1'b1);

    // Read with an empty buffer: srd at T+1, ack at T+2+L (L=2)
    n0 = cmds.size();
    access(1'b1, 1'b0, 32'h5014, 4'h0, 32'h0, lat, rdata, rv, rq, ac);
    check("erd_ncmd", cmds.size(), n0 + 1);
    if (cmds.size() > n0) begin
      c = cmds[n0];
      check("erd_start", c.start, rq + 1);
      check("erd_sa", c.sa, 29'hA00);
      check("erd_ack", ac, c.done + 1);
    end
    check("erd_lat", lat, 4);
    check("erd_data", rdata, 32'hA5);
    force_rd = 1'b0;
    wait_idle(20);

    // Idle timeout
    fix_lat = 1;
    access(1'b0, 1'b1, 32'h7000, 4'hF, 32'h5555_AAAA, lat, rdata, rv, rq, ac);
    n0 = cmd_starts;
    for (int i = 0; i < 200 && cmd_starts == n0; i++) begin
      @(posedge ck); #1;
    end
    check("tmo_started", cmd_starts, n0 + 1);
    check("tmo_delay", last_start_cyc - ac, 64);
    check("tmo_is_wr", last_start_wr, 1'b1);
    wait_idle(20);

    // Auto-flush disabled instance
    @(posedge ck); #1; req_wr0 = 1'b1;
    w = 0;
    for (int i = 0; i < 10 && !ack0; i++) begin
      @(posedge ck); #1; w = i + 1;
    end
    check("t0_ack", ack0, 1'b1);
    req_wr0 = 1'b0;
    repeat (1000) @(posedge ck);
    #1;
    check("t0_no_swr", swr0_cnt, 0);
    check("t0_busy", busy0, 1'b1);

    // Randomized traffic against a byte-memory model
    rand_lat = 1'b1;
    for (int it = 0; it < 200; it++) begin
      rsel = $urandom_range(0, 9);
      w = $urandom_range(0, 31);
      if (rsel < 6) begin
        req_be = 4'($urandom_range(1, 15));
        exp_w = $urandom;
        access(1'b0, 1'b1, 32'h4000 + 4 * w, req_be, exp_w, lat, rdata, rv, rq, ac);
        for (int b = 0; b < 4; b++)
          if (req_be[b]) ref_b[4 * w + b] = exp_w[8*b +: 8];
      end else if (rsel < 9) begin
        access(1'b1, 1'b0, 32'h4000 + 4 * w, 4'h0, 32'h0, lat, rdata, rv, rq, ac);
        exp_w = {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
        check("rnd_rdata", rdata, exp_w);
        check("rnd_rvalid", rv, 1'b1);
      end else if (rsel == 9 && w < 16) begin
        repeat ($urandom_range(0, 80)) @(posedge ck);
      end else begin
        pulse_flush();
      end
    end
    pulse_flush();
    wait_idle(100);
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 32; i++) exp_line[8*i +: 8] = ref_b[32 * l + i];
      line_tmp = rmem.exists(29'h800 + 29'(4 * l)) ? rmem[29'h800 + 29'(4 * l)] : '0;
      check("rnd_mem_line", line_tmp, exp_line);
    end
    rand_lat = 1'b0;

    // Reset while a write is outstanding, then a stray srdy
    resp_en = 1'b0;
    access(1'b0, 1'b1, 32'h8000, 4'hF, 32'hCAFE_F00D, lat, rdata, rv, rq, ac);
    pulse_flush();
    for (int i = 0; i < 20 && !swr; i++) begin
      @(posedge ck); #1;
    end
    check("rstmid_swr_seen", swr, 1'b1);
    @(posedge ck); #1; reset = 1'b1;
    @(posedge ck); #1;
    check("rstmid_swr", swr, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    reset = 1'b0;
    n0 = cmd_starts;
    w = ack_cnt;
    stray_req++;
    repeat (10) @(posedge ck);
    #1;
    check("stray_no_ack", ack_cnt, w);
    check("stray_no_cmd", cmd_starts, n0);
    check("stray_busy", busy, 1'b0);
    check("stray_smsk", smsk, 32'hFFFF_FFFF);

    check("protocol", mon_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
